// File: rtl/pico_ram_bridge_if.sv
// CPU-side PicoRV32 native bus plus the word-wide RAM port of the bridge.
// No latency of its own; it only bundles the wires.
// The CPU waits on mem_ready; the RAM side has no backpressure.
interface pico_ram_bridge_if;
  // PicoRV32 native memory bus
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;
  // RAM port (combinational read, write on rising edge while ram_wen is high)
  logic        ram_wen;
  logic [11:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Bridge view
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, bus_err,
    output ram_wen, ram_address, ram_wdata,
    input  ram_rdata
  );

  // Environment view: CPU driving requests and RAM returning read data
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, bus_err,
    input  ram_wen, ram_address, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/pico_ram_bridge.sv
// PicoRV32 native bus to single-port async-read RAM bridge with window decode.
// Fixed latency: request accepted at edge N, ram_wen in cycle N+1, mem_ready in cycle N+2.
// No request accepted in ACCESS/DONE; the CPU simply keeps mem_valid high until mem_ready.
// Optional byte-strobe read-modify-write merge: define PICO_RAM_BRIDGE_RMW_EN.
module pico_ram_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WINDOW_BITS = 12
) (
  input  logic             clk,
  input  logic             resetn,
  pico_ram_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Window bounds kept 33 bits wide so BASE_ADDR + size never wraps.
  localparam logic [32:0] LP_BASE  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LP_LIMIT = LP_BASE + (33'd1 << WINDOW_BITS);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [11:0] r_offset;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_in_range;
  logic [31:0] r_rdata;

  logic [31:0] w_req_addr;
  logic        w_in_range;
  logic [11:0] w_offset;
  logic        w_accept;
  logic        w_is_read;
  logic        w_ram_wen;
  logic        w_mem_ready;
  logic        w_bus_err;
  logic [31:0] w_wdata;
  logic        w_unused;

  // Word-align the request; the two byte-offset bits carry no meaning here.
  assign w_req_addr = {bus.mem_addr[31:2], 2'b00};

  // Bounds are checked on the full address, not on the subtracted offset, so
  // addresses below BASE_ADDR cannot alias into the window.
  assign w_in_range = ({1'b0, w_req_addr} >= LP_BASE) &&
                      ({1'b0, w_req_addr} <  LP_LIMIT);

  // Only the low 12 bits of the offset reach the RAM.
  assign w_offset = w_req_addr[11:0] - BASE_ADDR[11:0];

  // Instruction-fetch flag and byte-offset bits do not influence the bridge.
  assign w_unused = ^{bus.mem_instr, bus.mem_addr[1:0]};

  assign w_is_read = (r_wstrb == 4'h0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs; ram_wen comes straight from r_state
  // so an asynchronous reset removes it immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ram_wen   = 1'b0;
    w_mem_ready = 1'b0;
    w_bus_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_ram_wen   = !w_is_read && r_in_range;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_mem_ready = 1'b1;
        w_bus_err   = !r_in_range;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_offset   <= 12'h000;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_in_range <= 1'b0;
    end else if (w_accept) begin
      r_offset   <= w_offset;
      r_wdata    <= bus.mem_wdata;
      r_wstrb    <= bus.mem_wstrb;
      r_in_range <= w_in_range;
    end
  end

  // Register read data on the ACCESS-to-DONE edge; writes and misses return zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0;
    end else if (r_state == ACCESS) begin
      r_rdata <= (w_is_read && r_in_range) ? bus.ram_rdata : 32'h0;
    end
  end

`ifdef PICO_RAM_BRIDGE_RMW_EN
  // Merge strobed bytes over the current RAM word (single-cycle read-modify-write).
  always_comb begin
    w_wdata = bus.ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_wstrb[i]) begin
        w_wdata[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end
`else
  // Any nonzero strobe writes the whole latched word; RAM data serves reads only.
  always_comb begin
    w_wdata = r_wdata;
  end
`endif

  assign bus.ram_wen     = w_ram_wen;
  assign bus.ram_address = r_offset;
  assign bus.ram_wdata   = w_wdata;
  assign bus.mem_ready   = w_mem_ready;
  assign bus.bus_err     = w_bus_err;
  assign bus.mem_rdata   = r_rdata;

endmodule

// File: tb/tb_pico_ram_bridge.sv
// Scoreboard bench for pico_ram_bridge: directed requests push expected RAM writes and responses.
// A negedge monitor pops and compares whenever ram_wen or mem_ready is seen.
// A second instance with a high base address checks window decode below BASE_ADDR.
module tb_pico_ram_bridge;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  pico_ram_bridge_if bus0 ();
  pico_ram_bridge_if bus1 ();

  pico_ram_bridge #(.BASE_ADDR(32'h0000_0000), .WINDOW_BITS(12)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0.slave)
  );

  pico_ram_bridge #(.BASE_ADDR(32'h8000_0000), .WINDOW_BITS(12)) u_dut_hi (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1.slave)
  );

  // Second instance sees the same CPU requests; its RAM reads a fixed word.
  assign bus1.mem_valid = bus0.mem_valid;
  assign bus1.mem_instr = bus0.mem_instr;
  assign bus1.mem_addr  = bus0.mem_addr;
  assign bus1.mem_wdata = bus0.mem_wdata;
  assign bus1.mem_wstrb = bus0.mem_wstrb;
  assign bus1.ram_rdata = 32'h600D_CAFE;

`ifdef PICO_RAM_BRIDGE_RMW_EN
  localparam logic [31:0] BYTE_EXP = 32'h1122_33AA;
  localparam logic [31:0] HALF_EXP = 32'hBEEF_3210;
`else
  localparam logic [31:0] BYTE_EXP = 32'h0000_00AA;
  localparam logic [31:0] HALF_EXP = 32'hBEEF_0000;
`endif

  // RAM model: combinational read, write on rising edge
  logic [31:0] ram [0:1023];
  assign bus0.ram_rdata = ram[bus0.ram_address[11:2]];
  always @(posedge clk) begin
    if (bus0.ram_wen) ram[bus0.ram_address[11:2]] <= bus0.ram_wdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        err1;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT activity against the scoreboard queues.
  always @(negedge clk) begin : mon
    rsp_t e;
    wr_t  w;
    if (bus0.ram_wen) begin
      if (wq.size() == 0) begin
        chk("unexpected_ram_wen", 32'd1, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wen_addr", {20'h0, bus0.ram_address}, {20'h0, w.a});
        chk("wen_data", bus0.ram_wdata, w.d);
        chk("wen_cycle", cyc, w.cyc);
      end
    end
    if (bus0.mem_ready) begin
      if (rq.size() == 0) begin
        chk("unexpected_mem_ready", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        chk("rdata", bus0.mem_rdata, e.rd);
        chk("bus_err", {31'h0, bus0.bus_err}, {31'h0, e.err});
        chk("rdy_cycle", cyc, e.cyc);
        chk("hi_ready", {31'h0, bus1.mem_ready}, 32'd1);
        chk("hi_bus_err", {31'h0, bus1.bus_err}, {31'h0, e.err1});
      end
    end
    if (bus1.mem_ready && !bus0.mem_ready) chk("hi_ready_alone", 32'd1, 32'd0);
    if (bus1.ram_wen) chk("hi_unexpected_wen", 32'd1, 32'd0);
  end

  // One isolated request; expectations are pushed right after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_err1,
                       input logic exp_w, input logic [11:0] w_a, input logic [31:0] w_d);
    int n;
    @(negedge clk);
    bus0.mem_valid = 1'b1;
    bus0.mem_addr  = a;
    bus0.mem_wdata = d;
    bus0.mem_wstrb = s;
    @(posedge clk);
    #1;
    n = cyc;
    if (exp_w) wq.push_back('{a: w_a, d: w_d, cyc: n});
    rq.push_back('{rd: exp_rd, err: exp_err, err1: exp_err1, cyc: n + 1});
    bus0.mem_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0]  = 32'h0BAD_F00D;
    ram[1]  = 32'h0101_0101;
    ram[2]  = 32'h0202_0202;
    ram[6]  = 32'h7654_3210;
    ram[8]  = 32'hCAFE_F00D;
    ram[12] = 32'h1122_3344;

    bus0.mem_valid = 1'b0;
    bus0.mem_instr = 1'b0;
    bus0.mem_addr  = 32'h0;
    bus0.mem_wdata = 32'h0;
    bus0.mem_wstrb = 4'h0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_mem_ready", {31'h0, bus0.mem_ready}, 32'd0);
    chk("rst_bus_err", {31'h0, bus0.bus_err}, 32'd0);
    chk("rst_ram_wen", {31'h0, bus0.ram_wen}, 32'd0);
    chk("rst_mem_rdata", bus0.mem_rdata, 32'd0);
    chk("rst_ram_address", {20'h0, bus0.ram_address}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);

    // addr, wdata, wstrb, rdata, err, err(hi), wen?, wen addr, wen data
    issue(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
    issue(32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h0000_0030, 32'h0000_00AA, 4'h1, 32'h0,         1'b0, 1'b1, 1'b1, 12'h030, BYTE_EXP);
    issue(32'h0000_0030, 32'h0,         4'h0, BYTE_EXP,      1'b0, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h0000_0018, 32'hBEEF_0000, 4'hC, 32'h0,         1'b0, 1'b1, 1'b1, 12'h018, HALF_EXP);
    issue(32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h0000_0FFE, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 12'hFFC, 32'hA5A5_A5A5);
    issue(32'h0000_0FFC, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0);
    issue(32'h8000_0004, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0, 1'b0, 12'h000, 32'h0);
    issue(32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    chk("ram_after_oor_write", ram[0], 32'h0BAD_F00D);

    // Back-to-back reads with mem_valid held high: responses 3 cycles apart
    @(negedge clk);
    bus0.mem_valid = 1'b1;
    bus0.mem_addr  = 32'h0000_0004;
    bus0.mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    n = cyc;
    rq.push_back('{rd: 32'h0101_0101, err: 1'b0, err1: 1'b1, cyc: n + 1});
    bus0.mem_addr = 32'h0000_0008;
    repeat (3) @(posedge clk);
    #1;
    rq.push_back('{rd: 32'h0202_0202, err: 1'b0, err1: 1'b1, cyc: n + 4});
    bus0.mem_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Reset during ACCESS of a write: ram_wen drops at once, no write, no response
    @(negedge clk);
    bus0.mem_valid = 1'b1;
    bus0.mem_addr  = 32'h0000_0020;
    bus0.mem_wdata = 32'h5555_5555;
    bus0.mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    chk("access_wen_before_rst", {31'h0, bus0.ram_wen}, 32'd1);
    bus0.mem_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_wen_drop", {31'h0, bus0.ram_wen}, 32'd0);
    chk("rst_ready_low", {31'h0, bus0.mem_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    repeat (5) @(posedge clk);
    chk("ram_unchanged_after_rst", ram[8], 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    chk("rsp_queue_drained", rq.size(), 32'd0);
    chk("wen_queue_drained", wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
